arb_client_queue: RTL

- Upstream requester stage for the 2-client arbiter; one instance feeds the arbiter's request[1:0] and consumes its grant[1:0].
- Holds a per-client FIFO of pending data words. Raises request[i] while client i has work.
- On grant, transfers the head word of the granted client onto a shared valid/ready output bus.
- Drops request for one cycle after each transfer so the arbiter can rotate.

---
 rtl/arb_client_queue_if.sv | 19 +
 rtl/arb_client_queue.sv | 123 ++++++++++++
 2 files changed

// File: rtl/arb_client_queue_if.sv
// arb_client_queue_if: push, arbiter and output-bus signals of one arbiter client queue
// slave modport is the queue block; master modport is whatever drives it (arbiter, producers, sink)
interface arb_client_queue_if #(parameter int DW = 8);
  logic [1:0]    push;
  logic [DW-1:0] push_data0;
  logic [DW-1:0] push_data1;
  logic [1:0]    full;
  logic [1:0]    request;
  logic [1:0]    grant;
  logic          bus_valid;
  logic          bus_ready;
  logic [DW-1:0] bus_data;
  logic          bus_src;
  logic [2:0]    err;
  modport slave (input push, push_data0, push_data1, grant, bus_ready,
                 output full, request, bus_valid, bus_data, bus_src, err);
  modport master (output push, push_data0, push_data1, grant, bus_ready,
                  input full, request, bus_valid, bus_data, bus_src, err);
endinterface

// File: rtl/arb_client_queue.sv
// arb_client_queue: two per-client FIFOs feeding a 2-client arbiter and a shared valid/ready bus
// Ports: clk, rst (async, active-high); q (arb_client_queue_if.slave):
//   push/push_data0/push_data1 -> FIFO writes, full per client
//   request -> arbiter, grant <- arbiter (one-hot or zero)
//   bus_valid/bus_ready/bus_data/bus_src -> output word of the granted client
//   err: [0] overflow, [1] illegal grant, [2] timeout (sticky)
// Optional: define ARB_Q_TIMEOUT_EN to discard a head word after TIMEOUT stalled XFER cycles.
module arb_client_queue #(
  parameter int DEPTH   = 4,
  parameter int DW      = 8,
  parameter int TIMEOUT = 16
) (
  input logic clk,
  input logic rst,
  arb_client_queue_if.slave q
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  typedef enum logic [1:0] {IDLE, XFER, RELEASE} state_t;
  state_t        state_q;
  logic          sel_q;
  logic [1:0]    request_q;
  logic          bus_valid_q;
  logic [DW-1:0] bus_data_q;
  logic          bus_src_q;
  logic [2:0]    err_q;
  logic [DW-1:0] mem_q [2][DEPTH];
  logic [DW-1:0] mem_d [2][DEPTH];
  logic [AW-1:0] rp_q [2];
  logic [AW-1:0] rp_d [2];
  logic [AW-1:0] wp_q [2];
  logic [AW-1:0] wp_d [2];
  logic [CW-1:0] cnt_q [2];
  logic [CW-1:0] cnt_d [2];
  logic [DW-1:0] head [2];
  logic [1:0]    full, nonempty, pop, acc, ovf;
  logic          tmo_hit;
`ifdef ARB_Q_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_q, tmo_d;
  // fires on the TIMEOUT-th consecutive stalled XFER cycle
  assign tmo_hit = state_q == XFER && !q.bus_ready && tmo_q == TW'(TIMEOUT - 1);
  always_comb tmo_d = (state_q == XFER && !q.bus_ready && !tmo_hit) ? tmo_q + TW'(1) : '0;
  always_ff @(posedge clk or posedge rst)
    if (rst) tmo_q <= '0;
    else tmo_q <= tmo_d;
`else
  // feature off: never fires, XFER waits on bus_ready indefinitely
  assign tmo_hit = 1'b0 && (TIMEOUT > 0);
`endif
  assign full     = {cnt_q[1] == CW'(DEPTH), cnt_q[0] == CW'(DEPTH)};
  assign nonempty = {cnt_q[1] != '0, cnt_q[0] != '0};
  assign pop      = (state_q == XFER && (q.bus_ready || tmo_hit)) ? (sel_q ? 2'b10 : 2'b01) : 2'b00;
  // a same-cycle pop frees the slot a push into a full FIFO needs
  assign acc      = q.push & (~full | pop);
  assign ovf      = q.push & full & ~pop;
  always_comb begin
    mem_d = mem_q;
    for (int i = 0; i < 2; i++) begin
      head[i]  = mem_q[i][rp_q[i]];
      if (acc[i]) mem_d[i][wp_q[i]] = (i == 0) ? q.push_data0 : q.push_data1;
      wp_d[i]  = wp_q[i] + AW'(acc[i]);
      rp_d[i]  = rp_q[i] + AW'(pop[i]);
      cnt_d[i] = cnt_q[i] + CW'(acc[i]) - CW'(pop[i]);
    end
  end
  always_ff @(posedge clk) mem_q <= mem_d;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rp_q  <= '{default: '0};
      wp_q  <= '{default: '0};
      cnt_q <= '{default: '0};
    end else begin
      rp_q  <= rp_d;
      wp_q  <= wp_d;
      cnt_q <= cnt_d;
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q     <= IDLE;
      sel_q       <= 1'b0;
      request_q   <= '0;
      bus_valid_q <= 1'b0;
      bus_data_q  <= '0;
      bus_src_q   <= 1'b0;
      err_q       <= '0;
    end else begin
      if (|ovf) err_q[0] <= 1'b1;
      case (state_q)
        IDLE: begin
          request_q <= nonempty;
          // one-hot grant to a non-requesting client is as illegal as 2'b11
          if (q.grant == 2'b11 || (q.grant != 2'b00 && (q.grant & request_q) == 2'b00)) err_q[1] <= 1'b1;
          else if (q.grant != 2'b00) begin
            sel_q       <= q.grant[1];
            bus_src_q   <= q.grant[1];
            bus_data_q  <= head[q.grant[1]];
            bus_valid_q <= 1'b1;
            state_q     <= XFER;
          end
        end
        XFER: begin
          request_q <= sel_q ? {1'b1, nonempty[0]} : {nonempty[1], 1'b1};
          if (q.bus_ready || tmo_hit) begin
            bus_valid_q <= 1'b0;
            state_q     <= RELEASE;
            if (tmo_hit) err_q[2] <= 1'b1;
          end
        end
        RELEASE: begin
          request_q <= sel_q ? {1'b0, nonempty[0]} : {nonempty[1], 1'b0};
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  assign q.full      = full;
  assign q.request   = request_q;
  assign q.bus_valid = bus_valid_q;
  assign q.bus_data  = bus_data_q;
  assign q.bus_src   = bus_src_q;
  assign q.err       = err_q;
endmodule
